// File: rtl/parking_request_arbiter_pkg.sv
// parking_pkg: shared state, class and timeout constants for the parking request arbiter
package parking_pkg;
    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_ENT_PULSE  = 3'd1;
    localparam logic [2:0] S_ENT_WAIT   = 3'd2;
    localparam logic [2:0] S_EXT_PAY    = 3'd3;
    localparam logic [2:0] S_EXT_PULSE  = 3'd4;
    localparam logic [2:0] S_EXT_SETTLE = 3'd5;
    localparam logic [2:0] S_EXT_WAIT   = 3'd6;
    localparam logic [2:0] S_RESP       = 3'd7;
    typedef enum logic {CLS_ENT = 1'b0, CLS_EXT = 1'b1} cls_e;
    localparam int GATE_TO_DEF = 16;
    localparam int PAY_TO_DEF  = 64;
endpackage

// File: rtl/parking_request_arbiter_if.sv
// parking_request_arbiter_if: lane/kiosk handshakes and parking system control/status
interface parking_request_arbiter_if #(
    parameter int N_ENT = 2,
    parameter int N_EXT = 2
);
    logic [N_ENT-1:0]   ent_req, ent_ack, ent_nack;
    logic [N_EXT-1:0]   ext_req, ext_paid, ext_ack, ext_nack;
    logic [2*N_EXT-1:0] ext_slot;
    logic               entry_pulse, exit_pulse, payment_received;
    logic [1:0]         exit_car_select;
    logic               entry_gate, exit_gate, full_led;
    logic [3:0]         occupancy;
    logic               busy;
    logic [7:0]         timeout_cnt;
    modport master (
        output ent_req, ext_req, ext_slot, ext_paid, entry_gate, exit_gate, full_led, occupancy,
        input  ent_ack, ent_nack, ext_ack, ext_nack, entry_pulse, exit_pulse, payment_received,
               exit_car_select, busy, timeout_cnt
    );
    modport slave (
        input  ent_req, ext_req, ext_slot, ext_paid, entry_gate, exit_gate, full_led, occupancy,
        output ent_ack, ent_nack, ext_ack, ext_nack, entry_pulse, exit_pulse, payment_received,
               exit_car_select, busy, timeout_cnt
    );
endinterface

// File: rtl/parking_request_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first eligible index after the last grant
module rr_arbiter #(
    parameter int W = 2
) (
    input  logic [W-1:0] elig,
    input  logic [2:0]   last,
    output logic [W-1:0] gnt,
    output logic [2:0]   idx,
    output logic         any
);
    int j;
    always_comb begin
        gnt = '0;
        idx = '0;
        j = 0;
        // scan farthest to nearest so the nearest eligible index after last overwrites
        for (int i = W; i >= 1; i--) begin
            j = (int'(last) + i) % W;
            if (|(elig & (W'(1) << j))) begin
                gnt = W'(1) << j;
                idx = 3'(j);
            end
        end
    end
    assign any = |elig;
endmodule

// File: rtl/parking_request_arbiter.sv
// parking_request_arbiter: serializes lane entry and kiosk exit requests onto the parking system controls
module parking_request_arbiter
    import parking_pkg::*;
#(
    parameter int N_ENT   = 2,
    parameter int N_EXT   = 2,
    parameter int GATE_TO = GATE_TO_DEF,
    parameter int PAY_TO  = PAY_TO_DEF
) (
    input logic clk,
    input logic rst_n,
    parking_request_arbiter_if.slave bus
);
    logic [2:0]       state, nxt, cur_idx, ptr_e, ptr_x, idx_e, idx_x;
    logic [N_ENT-1:0] served_e, gnt_e, g_e;
    logic [N_EXT-1:0] served_x, gnt_x, g_x;
    logic             any_e, any_x, pick_x, occ_ok, paid, gto, pto, to_e, to_x, nack_e0, nack_x0;
    logic [1:0]       sel_slot;
    logic [15:0]      timer;
    cls_e             last_cls;

    rr_arbiter #(.W(N_ENT)) u_rr_ent (
        .elig(bus.ent_req & ~served_e), .last(ptr_e), .gnt(gnt_e), .idx(idx_e), .any(any_e)
    );
    rr_arbiter #(.W(N_EXT)) u_rr_ext (
        .elig(bus.ext_req & ~served_x), .last(ptr_x), .gnt(gnt_x), .idx(idx_x), .any(any_x)
    );

    assign pick_x   = any_x && (!any_e || bus.full_led || last_cls == CLS_ENT);
    assign sel_slot = 2'(bus.ext_slot >> (2 * idx_x));
    assign occ_ok   = bus.occupancy[sel_slot];
    assign paid     = |(bus.ext_paid & g_x);
    assign gto      = timer == 16'(GATE_TO - 1);
    assign pto      = timer == 16'(PAY_TO - 1);
    assign to_e     = state == S_ENT_WAIT && !bus.entry_gate && gto;
    assign to_x     = (state == S_EXT_WAIT && !bus.exit_gate && gto) || (state == S_EXT_PAY && !paid && pto);
    assign nack_e0  = state == S_IDLE && !pick_x && any_e && bus.full_led;
    assign nack_x0  = state == S_IDLE && pick_x && !occ_ok;

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:       nxt = pick_x ? (occ_ok ? S_EXT_PAY : S_RESP) : any_e ? (bus.full_led ? S_RESP : S_ENT_PULSE) : S_IDLE;
            S_ENT_PULSE:  nxt = S_ENT_WAIT;
            S_ENT_WAIT:   nxt = bus.entry_gate || to_e ? S_RESP : state;
            S_EXT_PAY:    nxt = paid ? S_EXT_PULSE : to_x ? S_RESP : state;
            S_EXT_PULSE:  nxt = S_EXT_SETTLE;
            S_EXT_SETTLE: nxt = S_EXT_WAIT;
            S_EXT_WAIT:   nxt = bus.exit_gate || to_x ? S_RESP : state;
            default:      nxt = S_IDLE;
        endcase
    end

    // outputs decode the next state so every pulse is a flop aligned with its state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                <= S_IDLE;
            timer                <= '0;
            cur_idx              <= '0;
            ptr_e                <= '0;
            ptr_x                <= '0;
            last_cls             <= CLS_EXT;
            served_e             <= '0;
            served_x             <= '0;
            g_e                  <= '0;
            g_x                  <= '0;
            bus.ent_ack          <= '0;
            bus.ent_nack         <= '0;
            bus.ext_ack          <= '0;
            bus.ext_nack         <= '0;
            bus.entry_pulse      <= 1'b0;
            bus.exit_pulse       <= 1'b0;
            bus.payment_received <= 1'b0;
            bus.exit_car_select  <= '0;
            bus.busy             <= 1'b0;
            bus.timeout_cnt      <= '0;
        end else begin
            state    <= nxt;
            timer    <= nxt != state ? '0 : timer + 16'd1;
            served_e <= bus.ent_req & (served_e | (state == S_RESP ? g_e : '0));
            served_x <= bus.ext_req & (served_x | (state == S_RESP ? g_x : '0));
            if (state == S_IDLE) begin
                g_e     <= pick_x ? '0 : gnt_e;
                g_x     <= pick_x ? gnt_x : '0;
                cur_idx <= pick_x ? idx_x : idx_e;
            end
            if (state == S_RESP) begin
                ptr_e    <= |g_e ? cur_idx : ptr_e;
                ptr_x    <= |g_x ? cur_idx : ptr_x;
                last_cls <= |g_x ? CLS_EXT : CLS_ENT;
            end
            if (state == S_IDLE && pick_x && occ_ok)
                bus.exit_car_select <= sel_slot;
            bus.entry_pulse      <= nxt == S_ENT_PULSE;
            bus.exit_pulse       <= nxt == S_EXT_PULSE;
            bus.payment_received <= nxt == S_EXT_SETTLE;
            bus.busy             <= nxt != S_IDLE;
            bus.ent_ack          <= state == S_ENT_WAIT && bus.entry_gate ? g_e : '0;
            bus.ext_ack          <= state == S_EXT_WAIT && bus.exit_gate ? g_x : '0;
            bus.ent_nack         <= nack_e0 ? gnt_e : to_e ? g_e : '0;
            bus.ext_nack         <= nack_x0 ? gnt_x : to_x ? g_x : '0;
            bus.timeout_cnt      <= bus.timeout_cnt + 8'((to_e || to_x) && bus.timeout_cnt != 8'hff);
        end
    end
endmodule

// File: tb/tb_parking_request_arbiter.sv
// tb_parking_request_arbiter: randomized transactions checked against a transaction-level arbitration model
module tb_parking_request_arbiter;
    localparam int NE = 2, NX = 2, GT = 16, PT = 64;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_chk = 0, n_pass = 0;
    int m_ptr_e, m_ptr_x, m_tcnt;
    bit m_last_ext;
    bit [NE-1:0] m_srv_e;
    bit [NX-1:0] m_srv_x;

    always #5 clk = ~clk;

    parking_request_arbiter_if #(.N_ENT(NE), .N_EXT(NX)) bus ();
    parking_request_arbiter #(.N_ENT(NE), .N_EXT(NX), .GATE_TO(GT), .PAY_TO(PT)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int pick(input int ptr, input int n, input logic [7:0] el);
        for (int i = 1; i <= n; i++)
            if (el[(ptr + i) % n]) return (ptr + i) % n;
        return 0;
    endfunction

    task automatic model_reset;
        m_ptr_e = 0;
        m_ptr_x = 0;
        m_tcnt = 0;
        m_last_ext = 1'b1;
        m_srv_e = '0;
        m_srv_x = '0;
    endtask

    task automatic bump_tcnt;
        if (m_tcnt < 255) m_tcnt++;
    endtask

    task automatic check_resp(input string tag, input logic [7:0] e_oh, input logic [7:0] x_oh, input bit ack);
        check({tag, ".ent_ack"},  32'(bus.ent_ack),  ack ? 32'(e_oh[NE-1:0]) : 32'd0);
        check({tag, ".ent_nack"}, 32'(bus.ent_nack), ack ? 32'd0 : 32'(e_oh[NE-1:0]));
        check({tag, ".ext_ack"},  32'(bus.ext_ack),  ack ? 32'(x_oh[NX-1:0]) : 32'd0);
        check({tag, ".ext_nack"}, 32'(bus.ext_nack), ack ? 32'd0 : 32'(x_oh[NX-1:0]));
        check({tag, ".tcnt"},     32'(bus.timeout_cnt), 32'(m_tcnt));
    endtask

    task automatic await_gate(input bit ext, input int gd, input logic [7:0] oh);
        int n;
        n = gd <= GT ? gd : GT;
        for (int i = 1; i <= n; i++) begin
            if (ext) bus.exit_gate = (i == gd);
            else bus.entry_gate = (i == gd);
            tick;
        end
        bus.entry_gate = 1'b0;
        bus.exit_gate = 1'b0;
        if (gd > GT) bump_tcnt;
        check_resp(ext ? "ext_gate" : "ent_gate", ext ? 8'd0 : oh, ext ? oh : 8'd0, gd <= GT);
    endtask

    task automatic run_round(input logic [NE-1:0] er, input logic [NX-1:0] xr, input logic [2*NX-1:0] sl,
                             input logic [3:0] occ, input logic full, input int pd, input int gd, input bit drop);
        logic [NE-1:0] el_e;
        logic [NX-1:0] el_x;
        logic [7:0] oh;
        bit use_x, ok;
        int k, slot, n;
        bus.ent_req = er;
        bus.ext_req = xr;
        bus.ext_slot = sl;
        bus.occupancy = occ;
        bus.full_led = full;
        m_srv_e &= er;
        m_srv_x &= xr;
        el_e = er & ~m_srv_e;
        el_x = xr & ~m_srv_x;
        use_x = (el_x != 0) && (el_e == 0 || full || !m_last_ext);
        tick;
        if (el_e == 0 && el_x == 0) begin
            check("idle.busy", 32'(bus.busy), 32'd0);
            return;
        end
        k = use_x ? pick(m_ptr_x, NX, 8'(el_x)) : pick(m_ptr_e, NE, 8'(el_e));
        oh = 8'd1 << k;
        slot = int'(2'(sl >> (2 * k)));
        ok = use_x ? occ[slot] : !full;
        check("grant.busy", 32'(bus.busy), 32'd1);
        if (drop) begin
            if (use_x) bus.ext_req[k] = 1'b0;
            else bus.ent_req[k] = 1'b0;
        end
        if (!ok) begin
            check("imm.exit_pulse", 32'(bus.exit_pulse), 32'd0);
            check_resp("imm", use_x ? 8'd0 : oh, use_x ? oh : 8'd0, 1'b0);
        end else if (!use_x) begin
            check("entry_pulse", 32'(bus.entry_pulse), 32'd1);
            tick;
            check("entry_pulse.fall", 32'(bus.entry_pulse), 32'd0);
            await_gate(1'b0, gd, oh);
        end else begin
            check("car_select", 32'(bus.exit_car_select), 32'(slot));
            check("exit_pulse.early", 32'(bus.exit_pulse), 32'd0);
            n = pd <= PT ? pd : PT;
            for (int i = 1; i <= n; i++) begin
                bus.ext_paid = (i == pd) ? NX'(oh) : '0;
                tick;
            end
            bus.ext_paid = '0;
            if (pd > PT) begin
                bump_tcnt;
                check_resp("pay_to", 8'd0, oh, 1'b0);
            end else begin
                check("exit_pulse", 32'(bus.exit_pulse), 32'd1);
                check("pay_rcv.early", 32'(bus.payment_received), 32'd0);
                tick;
                check("pay_rcv", 32'(bus.payment_received), 32'd1);
                check("exit_pulse.fall", 32'(bus.exit_pulse), 32'd0);
                tick;
                await_gate(1'b1, gd, oh);
            end
        end
        tick;
        check("done.busy", 32'(bus.busy), 32'd0);
        check_resp("done", 8'd0, 8'd0, 1'b1);
        if (use_x) begin
            m_ptr_x = k;
            m_srv_x[k] = !drop;
        end else begin
            m_ptr_e = k;
            m_srv_e[k] = !drop;
        end
        m_last_ext = use_x;
        if (drop) begin
            bus.ent_req = '0;
            bus.ext_req = '0;
            tick;
            m_srv_e = '0;
            m_srv_x = '0;
            check("drop.busy", 32'(bus.busy), 32'd0);
        end
    endtask

    task automatic clear_round;
        run_round('0, '0, '0, '0, 1'b0, 1, 1, 1'b0);
    endtask

    initial begin
        bus.ent_req = '0;
        bus.ext_req = '0;
        bus.ext_slot = '0;
        bus.ext_paid = '0;
        bus.entry_gate = 1'b0;
        bus.exit_gate = 1'b0;
        bus.full_led = 1'b0;
        bus.occupancy = '0;
        model_reset;
        repeat (2) tick;
        check("rst.busy", 32'(bus.busy), 32'd0);
        check("rst.sel", 32'(bus.exit_car_select), 32'd0);
        check("rst.pulses", {29'd0, bus.entry_pulse, bus.exit_pulse, bus.payment_received}, 32'd0);
        check_resp("rst", 8'd0, 8'd0, 1'b1);
        rst_n = 1'b1;
        tick;
        run_round(2'b10, 2'b00, 4'b0000, 4'b0000, 1'b0, 1, 2, 1'b0);
        clear_round;
        run_round(2'b01, 2'b10, 4'b1000, 4'b1111, 1'b1, 3, 2, 1'b0);
        run_round(2'b01, 2'b10, 4'b1000, 4'b1111, 1'b1, 3, 2, 1'b0);
        clear_round;
        repeat (4) begin
            run_round(2'b11, 2'b00, 4'b0000, 4'b1111, 1'b0, 1, 1, 1'b0);
            clear_round;
        end
        repeat (4) begin
            run_round(2'b11, 2'b11, 4'b0100, 4'b1111, 1'b0, 2, 1, 1'b0);
            clear_round;
        end
        run_round(2'b00, 2'b01, 4'b0011, 4'b0111, 1'b0, 1, 1, 1'b0);
        clear_round;
        repeat (200)
            run_round(NE'($urandom), NX'($urandom), (2*NX)'($urandom), 4'($urandom), 1'($urandom),
                      ($urandom_range(0, 7) == 0) ? PT + 1 : int'($urandom_range(1, 6)),
                      ($urandom_range(0, 7) == 0) ? GT + 1 : int'($urandom_range(1, 5)),
                      $urandom_range(0, 3) == 0);
        clear_round;
        repeat (260) begin
            run_round(2'b00, 2'b01, 4'b0000, 4'b0001, 1'b0, PT + 1, 1, 1'b0);
            clear_round;
        end
        bus.ext_req = 2'b01;
        bus.ext_slot = '0;
        bus.occupancy = 4'b0001;
        bus.full_led = 1'b0;
        tick;
        bus.ext_paid = 2'b01;
        tick;
        bus.ext_paid = '0;
        repeat (3) tick;
        #2 rst_n = 1'b0;
        #1;
        model_reset;
        check("midrst.busy", 32'(bus.busy), 32'd0);
        check("midrst.sel", 32'(bus.exit_car_select), 32'd0);
        check("midrst.pulses", {29'd0, bus.entry_pulse, bus.exit_pulse, bus.payment_received}, 32'd0);
        check_resp("midrst", 8'd0, 8'd0, 1'b1);
        @(posedge clk);
        #2 rst_n = 1'b1;
        run_round(2'b00, 2'b01, 4'b0000, 4'b0001, 1'b0, 2, 3, 1'b0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
